cva6_su_buffer_model: RTL and testbench

Parametrised two-stage store buffer model for the CVA6 load/store unit verification environment. Accepted stores first wait in a speculative queue. Committed stores move to a commit queue, which drains to the data cache through a request/grant handshake. Depths and widths are parameters, and the block adds what single-entry store tracking lacks: a flush of speculative stores and page-offset hazard detection against all buffered entries.

---
 rtl/cva6_su_buffer_model.sv | 224 ++++++++++++++++++++++
 tb/tb_cva6_su_buffer_model.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_su_buffer_model.sv
// ---------------------------------------------------------------------------
// cva6_su_buffer_model
//
// Two-stage store buffer model for the CVA6 load/store unit. A store that is
// accepted first waits in a speculative FIFO. A commit moves the oldest
// speculative store into a commit FIFO. The commit FIFO drains to the data
// cache through a req/gnt handshake. Speculative stores can be flushed.
// Committed stores are never flushed. A combinational page-offset compare
// reports a hazard against every buffered store in both FIFOs.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   flush_i                       drop all speculative stores
//   store_valid_i/store_ready_o   store push handshake
//   store_paddr_i/data_i/be_i/trans_id_i  store payload
//   commit_i/commit_ready_o       move the oldest speculative store to commit
//   mem_req_o/mem_gnt_i           commit-queue head towards the cache
//   mem_addr_o/data_o/be_o        commit-queue head payload
//   page_offset_i                 load page offset to compare
//   page_offset_matches_o         offset hits any buffered store
//   spec_count_o, commit_count_o  occupancy of each FIFO
//   no_st_pending_o, empty_o      commit FIFO empty / both FIFOs empty
// ---------------------------------------------------------------------------
module cva6_su_buffer_model #(
    parameter int unsigned DEPTH_SPEC    = 4,
    parameter int unsigned DEPTH_COMMIT  = 8,
    parameter int unsigned PLEN          = 34,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  flush_i,
    input  logic                                  store_valid_i,
    output logic                                  store_ready_o,
    input  logic [PLEN-1:0]                       store_paddr_i,
    input  logic [XLEN-1:0]                       store_data_i,
    input  logic [XLEN/8-1:0]                     store_be_i,
    input  logic [TRANS_ID_BITS-1:0]              store_trans_id_i,
    input  logic                                  commit_i,
    output logic                                  commit_ready_o,
    output logic                                  mem_req_o,
    input  logic                                  mem_gnt_i,
    output logic [PLEN-1:0]                       mem_addr_o,
    output logic [XLEN-1:0]                       mem_data_o,
    output logic [XLEN/8-1:0]                     mem_be_o,
    input  logic [11:0]                           page_offset_i,
    output logic                                  page_offset_matches_o,
    output logic [$clog2(DEPTH_SPEC+1)-1:0]       spec_count_o,
    output logic [$clog2(DEPTH_COMMIT+1)-1:0]     commit_count_o,
    output logic                                  no_st_pending_o,
    output logic                                  empty_o
);

    localparam int unsigned BE_W    = XLEN / 8;
    localparam int unsigned OFF_LSB = $clog2(BE_W);
    localparam int unsigned SPTR_W  = (DEPTH_SPEC > 1) ? $clog2(DEPTH_SPEC) : 1;
    localparam int unsigned CPTR_W  = (DEPTH_COMMIT > 1) ? $clog2(DEPTH_COMMIT) : 1;
    localparam int unsigned SCNT_W  = $clog2(DEPTH_SPEC + 1);
    localparam int unsigned CCNT_W  = $clog2(DEPTH_COMMIT + 1);

    typedef struct packed {
        logic [PLEN-1:0]          paddr;
        logic [XLEN-1:0]          data;
        logic [BE_W-1:0]          be;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } entry_t;

    // Pointer increment with an explicit wrap, so a depth of 1 also works.
    function automatic logic [SPTR_W-1:0] spec_ptr_inc(input logic [SPTR_W-1:0] p);
        return (p == SPTR_W'(DEPTH_SPEC - 1)) ? '0 : p + SPTR_W'(1);
    endfunction

    function automatic logic [CPTR_W-1:0] commit_ptr_inc(input logic [CPTR_W-1:0] p);
        return (p == CPTR_W'(DEPTH_COMMIT - 1)) ? '0 : p + CPTR_W'(1);
    endfunction

    // Storage is never reset. Per-slot valid bits track which entries are live.
    entry_t spec_mem_q   [DEPTH_SPEC];
    entry_t commit_mem_q [DEPTH_COMMIT];

    logic [SPTR_W-1:0]       spec_wr_q, spec_wr_d, spec_rd_q, spec_rd_d;
    logic [CPTR_W-1:0]       commit_wr_q, commit_wr_d, commit_rd_q, commit_rd_d;
    logic [SCNT_W-1:0]       spec_count_q, spec_count_d;
    logic [CCNT_W-1:0]       commit_count_q, commit_count_d;
    logic [DEPTH_SPEC-1:0]   spec_vld_q, spec_vld_d;
    logic [DEPTH_COMMIT-1:0] commit_vld_q, commit_vld_d;

    logic   push_en, commit_en, drain_en;
    entry_t push_entry, head_entry;

    assign store_ready_o  = (spec_count_q != SCNT_W'(DEPTH_SPEC));
    // Depends on registered counts only, so there is no path from mem_gnt_i.
    assign commit_ready_o = (spec_count_q != '0) && (commit_count_q != CCNT_W'(DEPTH_COMMIT));
    assign mem_req_o      = (commit_count_q != '0);

    // A flush drops a same-cycle push. A same-cycle commit is still honoured.
    assign push_en   = store_valid_i && store_ready_o && !flush_i;
    assign commit_en = commit_i && commit_ready_o;
    assign drain_en  = mem_req_o && mem_gnt_i;

    assign push_entry = '{paddr: store_paddr_i, data: store_data_i,
                          be: store_be_i, trans_id: store_trans_id_i};

    assign head_entry = commit_mem_q[commit_rd_q];
    assign mem_addr_o = head_entry.paddr;
    assign mem_data_o = head_entry.data;
    assign mem_be_o   = head_entry.be;

    assign spec_count_o    = spec_count_q;
    assign commit_count_o  = commit_count_q;
    assign no_st_pending_o = (commit_count_q == '0);
    assign empty_o         = (commit_count_q == '0) && (spec_count_q == '0);

    // The trans_id and the sub-word offset bits are kept but never compared.
    logic unused_bits;
    assign unused_bits = ^{head_entry.trans_id, page_offset_i[OFF_LSB-1:0]};

    // Speculative queue control
    always_comb begin
        spec_wr_d    = spec_wr_q;
        spec_rd_d    = spec_rd_q;
        spec_count_d = spec_count_q;
        spec_vld_d   = spec_vld_q;

        if (commit_en) begin
            spec_rd_d             = spec_ptr_inc(spec_rd_q);
            spec_vld_d[spec_rd_q] = 1'b0;
        end
        if (push_en) begin
            spec_wr_d             = spec_ptr_inc(spec_wr_q);
            spec_vld_d[spec_wr_q] = 1'b1;
        end

        unique case ({push_en, commit_en})
            2'b10:   spec_count_d = spec_count_q + SCNT_W'(1);
            2'b01:   spec_count_d = spec_count_q - SCNT_W'(1);
            default: spec_count_d = spec_count_q;
        endcase

        if (flush_i) begin
            spec_wr_d    = '0;
            spec_rd_d    = '0;
            spec_count_d = '0;
            spec_vld_d   = '0;
        end
    end

    // Commit queue control
    always_comb begin
        commit_wr_d    = commit_wr_q;
        commit_rd_d    = commit_rd_q;
        commit_count_d = commit_count_q;
        commit_vld_d   = commit_vld_q;

        // The write slot is free when commit_en is set, and the read slot is live
        // when drain_en is set, so the two never alias.
        if (drain_en) begin
            commit_rd_d               = commit_ptr_inc(commit_rd_q);
            commit_vld_d[commit_rd_q] = 1'b0;
        end
        if (commit_en) begin
            commit_wr_d               = commit_ptr_inc(commit_wr_q);
            commit_vld_d[commit_wr_q] = 1'b1;
        end

        unique case ({commit_en, drain_en})
            2'b10:   commit_count_d = commit_count_q + CCNT_W'(1);
            2'b01:   commit_count_d = commit_count_q - CCNT_W'(1);
            default: commit_count_d = commit_count_q;
        endcase
    end

    // Hazard check against every live entry in both queues. Byte lanes within a
    // word are ignored, so a hit is reported at word granularity.
    always_comb begin
        page_offset_matches_o = 1'b0;
        for (int i = 0; i < int'(DEPTH_SPEC); i++) begin
            if (spec_vld_q[i] &&
                (spec_mem_q[i].paddr[11:OFF_LSB] == page_offset_i[11:OFF_LSB])) begin
                page_offset_matches_o = 1'b1;
            end
        end
        for (int i = 0; i < int'(DEPTH_COMMIT); i++) begin
            if (commit_vld_q[i] &&
                (commit_mem_q[i].paddr[11:OFF_LSB] == page_offset_i[11:OFF_LSB])) begin
                page_offset_matches_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spec_wr_q      <= '0;
            spec_rd_q      <= '0;
            spec_count_q   <= '0;
            spec_vld_q     <= '0;
            commit_wr_q    <= '0;
            commit_rd_q    <= '0;
            commit_count_q <= '0;
            commit_vld_q   <= '0;
        end else begin
            spec_wr_q      <= spec_wr_d;
            spec_rd_q      <= spec_rd_d;
            spec_count_q   <= spec_count_d;
            spec_vld_q     <= spec_vld_d;
            commit_wr_q    <= commit_wr_d;
            commit_rd_q    <= commit_rd_d;
            commit_count_q <= commit_count_d;
            commit_vld_q   <= commit_vld_d;
        end
    end

    // Payload storage, not reset
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            spec_mem_q[spec_wr_q] <= push_entry;
        end
        if (commit_en) begin
            commit_mem_q[commit_wr_q] <= spec_mem_q[spec_rd_q];
        end
    end

endmodule

// File: tb/tb_cva6_su_buffer_model.sv
// ---------------------------------------------------------------------------
// tb_cva6_su_buffer_model
//
// Directed bench for cva6_su_buffer_model with the default parameters
// (4 speculative entries, 8 commit entries, PLEN=34, XLEN=32).
// ---------------------------------------------------------------------------
module tb_cva6_su_buffer_model;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        store_valid_i;
    logic        store_ready_o;
    logic [33:0] store_paddr_i;
    logic [31:0] store_data_i;
    logic [3:0]  store_be_i;
    logic [2:0]  store_trans_id_i;
    logic        commit_i;
    logic        commit_ready_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [33:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_be_o;
    logic [11:0] page_offset_i;
    logic        page_offset_matches_o;
    logic [2:0]  spec_count_o;
    logic [3:0]  commit_count_o;
    logic        no_st_pending_o;
    logic        empty_o;

    int n_chk = 0;
    int n_bad = 0;
    logic [33:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    cva6_su_buffer_model dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .flush_i               (flush_i),
        .store_valid_i         (store_valid_i),
        .store_ready_o         (store_ready_o),
        .store_paddr_i         (store_paddr_i),
        .store_data_i          (store_data_i),
        .store_be_i            (store_be_i),
        .store_trans_id_i      (store_trans_id_i),
        .commit_i              (commit_i),
        .commit_ready_o        (commit_ready_o),
        .mem_req_o             (mem_req_o),
        .mem_gnt_i             (mem_gnt_i),
        .mem_addr_o            (mem_addr_o),
        .mem_data_o            (mem_data_o),
        .mem_be_o              (mem_be_o),
        .page_offset_i         (page_offset_i),
        .page_offset_matches_o (page_offset_matches_o),
        .spec_count_o          (spec_count_o),
        .commit_count_o        (commit_count_o),
        .no_st_pending_o       (no_st_pending_o),
        .empty_o               (empty_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_i          = 1'b0;
        store_valid_i    = 1'b0;
        store_paddr_i    = '0;
        store_data_i     = '0;
        store_be_i       = '0;
        store_trans_id_i = '0;
        commit_i         = 1'b0;
        mem_gnt_i        = 1'b0;
    endtask

    task automatic set_store(input logic [33:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic [2:0] id);
        store_valid_i    = 1'b1;
        store_paddr_i    = a;
        store_data_i     = d;
        store_be_i       = be;
        store_trans_id_i = id;
    endtask

    // Commit whatever is committable and grant every request. Each granted head
    // address is compared against the front of exp_q. The loop is bounded.
    task automatic drain_all(input string tag);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || !empty_o) && guard < 64) begin
            commit_i  = commit_ready_o;
            mem_gnt_i = 1'b1;
            if (mem_req_o) begin
                if (exp_q.size() != 0) chk({tag, "_addr"}, mem_addr_o, exp_q.pop_front());
                else                   chk({tag, "_extra"}, mem_req_o, 1'b0);
            end
            tick();
            guard++;
        end
        commit_i  = 1'b0;
        mem_gnt_i = 1'b0;
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_empty"}, empty_o, 1'b1);
    endtask

    initial begin
        idle();
        page_offset_i = '0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state
        chk("rst_store_ready",  store_ready_o,         1'b1);
        chk("rst_commit_ready", commit_ready_o,        1'b0);
        chk("rst_mem_req",      mem_req_o,             1'b0);
        chk("rst_match",        page_offset_matches_o, 1'b0);
        chk("rst_spec_count",   spec_count_o,          3'd0);
        chk("rst_commit_count", commit_count_o,        4'd0);
        chk("rst_no_st_pend",   no_st_pending_o,       1'b1);
        chk("rst_empty",        empty_o,               1'b1);

        // Single store through both stages at minimum latency
        set_store(34'h0_0000_1004, 32'hDEAD_BEEF, 4'hF, 3'd1);
        tick();
        idle();
        chk("one_spec_count",   spec_count_o,   3'd1);
        chk("one_commit_ready", commit_ready_o, 1'b1);
        chk("one_req_early",    mem_req_o,      1'b0);
        commit_i = 1'b1;
        tick();
        idle();
        chk("one_req",          mem_req_o,      1'b1);
        chk("one_addr",         mem_addr_o,     34'h1004);
        chk("one_data",         mem_data_o,     32'hDEAD_BEEF);
        chk("one_be",           mem_be_o,       4'hF);
        chk("one_commit_count", commit_count_o, 4'd1);
        chk("one_spec_empty",   spec_count_o,   3'd0);
        chk("one_no_st_pend",   no_st_pending_o, 1'b0);
        mem_gnt_i = 1'b1;
        tick();
        idle();
        chk("one_empty",        empty_o,        1'b1);
        chk("one_req_after",    mem_req_o,      1'b0);
        chk("one_no_st_after",  no_st_pending_o, 1'b1);

        // Fill the speculative queue. A fifth push is refused.
        for (int i = 0; i < 4; i++) begin
            set_store(34'h100 + 34'(4 * i), 32'hA0 + 32'(i), 4'hF, 3'(i));
            tick();
        end
        idle();
        chk("fill_ready",     store_ready_o, 1'b0);
        chk("fill_count",     spec_count_o,  3'd4);
        set_store(34'h999, 32'h5555_5555, 4'hF, 3'd7);
        tick();
        idle();
        chk("fill_drop_count", spec_count_o, 3'd4);
        for (int i = 0; i < 4; i++) exp_q.push_back(34'h100 + 34'(4 * i));
        drain_all("fill_order");

        // Fill the commit queue with no grants. One spec entry is left waiting.
        for (int i = 0; i < 9; i++) begin
            set_store(34'h200 + 34'(4 * i), 32'hB0 + 32'(i), 4'h3, 3'(i));
            commit_i = commit_ready_o;
            tick();
        end
        idle();
        chk("cqf_commit_count", commit_count_o, 4'd8);
        chk("cqf_spec_count",   spec_count_o,   3'd1);
        chk("cqf_commit_ready", commit_ready_o, 1'b0);
        chk("cqf_store_ready",  store_ready_o,  1'b1);
        chk("cqf_head",         mem_addr_o,     34'h200);
        mem_gnt_i = 1'b1;
        tick();
        idle();
        chk("cqf_ready_after",  commit_ready_o, 1'b1);
        chk("cqf_count_after",  commit_count_o, 4'd7);
        for (int i = 1; i < 9; i++) exp_q.push_back(34'h200 + 34'(4 * i));
        drain_all("cqf_order");

        // Flush with a same-cycle commit and push
        set_store(34'h300, 32'hC0, 4'hF, 3'd0);
        tick();
        set_store(34'h304, 32'hC1, 4'hF, 3'd1);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        set_store(34'h308, 32'hC2, 4'hF, 3'd2);
        tick();
        set_store(34'h30C, 32'hC3, 4'hF, 3'd3);
        tick();
        idle();
        chk("fl_pre_spec",   spec_count_o,   3'd3);
        chk("fl_pre_commit", commit_count_o, 4'd1);
        set_store(34'h310, 32'hC4, 4'hF, 3'd4);
        flush_i  = 1'b1;
        commit_i = 1'b1;
        tick();
        idle();
        chk("fl_spec",         spec_count_o,   3'd0);
        chk("fl_commit",       commit_count_o, 4'd2);
        chk("fl_commit_ready", commit_ready_o, 1'b0);
        chk("fl_store_ready",  store_ready_o,  1'b1);
        exp_q.push_back(34'h300);
        exp_q.push_back(34'h304);
        drain_all("fl_order");

        // Page-offset hazard in each stage and after the drain
        set_store(34'h2A3C, 32'h1234_5678, 4'hF, 3'd5);
        tick();
        idle();
        page_offset_i = 12'hA3C;
        #1;
        chk("haz_spec_hit",  page_offset_matches_o, 1'b1);
        page_offset_i = 12'hA40;
        #1;
        chk("haz_spec_miss", page_offset_matches_o, 1'b0);
        page_offset_i = 12'hA3D;
        #1;
        chk("haz_byte_hit",  page_offset_matches_o, 1'b1);
        commit_i = 1'b1;
        tick();
        idle();
        page_offset_i = 12'hA3C;
        #1;
        chk("haz_cq_hit",    page_offset_matches_o, 1'b1);
        mem_gnt_i = 1'b1;
        tick();
        idle();
        chk("haz_drained",   page_offset_matches_o, 1'b0);
        chk("haz_empty",     empty_o,               1'b1);
        page_offset_i = '0;

        // Reset while two committed stores wait with no grant
        set_store(34'h400, 32'hD0, 4'hF, 3'd0);
        tick();
        set_store(34'h404, 32'hD1, 4'hF, 3'd1);
        commit_i = 1'b1;
        tick();
        store_valid_i = 1'b0;
        commit_i      = 1'b1;
        tick();
        idle();
        chk("rmd_commit_count", commit_count_o, 4'd2);
        chk("rmd_req",          mem_req_o,      1'b1);
        rst_i = 1'b1;
        set_store(34'h408, 32'hD2, 4'hF, 3'd2);
        tick();
        rst_i = 1'b0;
        idle();
        chk("rmd_req_after",    mem_req_o,      1'b0);
        chk("rmd_empty",        empty_o,        1'b1);
        chk("rmd_spec_count",   spec_count_o,   3'd0);
        chk("rmd_commit_after", commit_count_o, 4'd0);
        tick();
        chk("rmd_store_ready",  store_ready_o,  1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
